apb_regfile_slave: RTL and testbench
====================================

Name: apb_regfile_slave

Overview:
- APB responder (completer) for the bridge's APB side: decodes one bit of the 3-bit psel bus, owns a small 32-bit register file, and returns prdata/pready/pslverr.
- Word 0 is a read-only ID register; words 1..NREGS-1 are read/write.
- All registers are driven out on a flat bus for use by the peripheral logic.
- One instance is built per psel bit.

Parameters:
- SEL_IDX, 0, index of the psel bit that selects this slave (0..2).
- NREGS, 8, number of 32-bit words (power of 2, 2..64).
- ID_VALUE, 32'hA9B0_0001, read-only contents of word 0.
- WAIT_CYCLES, 2, wait states per access (used only with APB_WAIT_STATES_EN, 1..15).

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous, active-high reset.
- psel  in  3  slave selects from the APB controller; this slave uses psel[SEL_IDX].
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid while pready=1 in the access phase.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, qualified by pready.
- reg_out  out  NREGS*32  flat register contents; word i sits at bits [32i+31:32i]; word 0 = ID_VALUE.
- proto_err  out  1  sticky flag: a setup phase was not followed by a matching access phase.

Behaviour:
- Reset (async, hreset=1): state ST_IDLE; prdata=0, pready=0, pslverr=0, proto_err=0; RW words=0. An in-flight write is discarded.
- Phase decode: sel = psel[SEL_IDX]. Setup = sel & ~penable. Access = sel & penable.
- Address decode:
  - idx = paddr[31:2].
  - err = (paddr[1:0]!=0) | (idx >= NREGS) | (pwrite & idx==0).
- State machine:
  - ST_IDLE:
    - On a clock edge with setup: latch addr/pwrite/pwdata and err; prdata <= read value of word idx (or 0 if err or write); go to ST_ACCESS.
    - Access seen without a preceding setup: ignored; set proto_err; stay in ST_IDLE.
  - ST_ACCESS:
    - pready=1 combinationally; pslverr = latched err.
    - On an edge with access: if the latched pwrite is set and err=0, write the latched data to the latched word; go to ST_IDLE.
    - On an edge without access (sel or penable low): abort with no write; set proto_err. If a setup is present on that edge, treat it as a new setup (re-latch, stay in ST_ACCESS); otherwise go to ST_IDLE.
  - ST_WAIT: exists only with the feature.
- Outputs by state:
  - pready=0 and pslverr=0 outside the completing access cycle.
  - prdata holds its last value until the next setup.
- Latency: zero wait states; each transfer takes 2 cycles (setup + access). Back-to-back transfers (setup immediately after access) are supported with no idle cycle.
- A write is visible on reg_out the cycle after its access edge. A read of the same word in the immediately following transfer returns the new value.
- Other psel bits are ignored entirely. psel with multiple bits set is handled on this slave's bit alone.
- proto_err clears only on reset.

Optional Feature:
- Macro: APB_WAIT_STATES_EN.
- With the macro defined:
  - Setup moves to ST_WAIT instead of ST_ACCESS, loading a 4-bit counter with WAIT_CYCLES.
  - In ST_WAIT, pready=0 and the counter decrements each edge on which access holds; at 0 the block goes to ST_ACCESS.
  - If access drops during ST_WAIT: abort, proto_err=1, no write.
  - prdata is sampled at entry to ST_ACCESS.
- Without the macro: ST_WAIT and the counter are not built, and pready is high in every access cycle. This matches a controller that does not sample pready.

Test Plan:
- Write: setup with psel[SEL_IDX]=1, paddr=0x4, pwdata=0xDEADBEEF, then access. Read back paddr 0x4: prdata=0xDEADBEEF, pready=1, pslverr=0, reg_out[63:32]=0xDEADBEEF.
- ID register: read paddr 0x0 -> prdata=0xA9B00001. Write 0x12345678 to 0x0 -> pslverr=1, word 0 unchanged.
- Decode errors: read paddr 0x20 (idx 8) -> prdata=0, pslverr=1. Write paddr 0x6 (misaligned) -> pslverr=1, no register changes.
- Deselect: full transfer using a different psel bit -> pready stays 0, all regs unchanged. Setup followed by psel dropping -> no write, proto_err=1 and stays 1.
- Back-to-back: write 0x1 to 0x8, then immediately read 0x8 -> prdata=0x1. Assert hreset mid-access -> outputs return to reset values immediately, word 2 reads 0.
- With APB_WAIT_STATES_EN and WAIT_CYCLES=2: write to 0xC -> pready low for 2 access cycles and high on the 3rd; the register updates only after the 3rd edge.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB completer with ID word and RW register file; option APB_WAIT_STATES_EN adds wait states
module apb_regfile_slave #(
    parameter int          SEL_IDX     = 0,
    parameter int          NREGS       = 8,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [2:0]           psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [NREGS*32-1:0]  reg_out,
    output logic                 proto_err
);

    localparam int IDX_W = $clog2(NREGS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [1:0]       setup_target;
    logic             sel;
    logic             setup;
    logic             access;
    logic [IDX_W-1:0] idx_lo;
    logic             dec_err;
    logic [31:0]      live_rd;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_write;
    logic [31:0]      lat_wdata;
    logic             lat_err;
    logic             wr_en;
    logic             unused_psel;

    assign sel    = psel[SEL_IDX];
    assign setup  = sel & ~penable;
    assign access = sel & penable;
    assign unused_psel = ^psel;

    assign idx_lo  = paddr[IDX_W+1:2];
    assign dec_err = (paddr[1:0] != 2'b00)
                   | (paddr[31:2] >= 30'(NREGS))
                   | (pwrite & (paddr[31:2] == 30'd0));
    assign live_rd = reg_out[{idx_lo, 5'd0} +: 32];

    assign pready  = (state == ST_ACCESS) & access;
    assign pslverr = pready & lat_err;
    assign wr_en   = pready & lat_write & ~lat_err;

`ifdef APB_WAIT_STATES_EN
    logic [3:0]  wait_cnt;
    logic [31:0] lat_rd;
    logic        wait_done;

    assign lat_rd       = reg_out[{lat_idx, 5'd0} +: 32];
    assign wait_done    = (state == ST_WAIT) & access & (wait_cnt == 4'd1);
    assign setup_target = ST_WAIT;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wait_cnt <= 4'd0;
        end else if (setup) begin
            wait_cnt <= 4'(WAIT_CYCLES);
        end else if ((state == ST_WAIT) && access) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`else
    assign setup_target = ST_ACCESS;
`endif

    // A setup can only appear while no access is present, so it always
    // (re)starts a transfer, aborting whatever was pending.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = setup ? setup_target : ST_IDLE;
            ST_ACCESS: state_next = (!access && setup) ? setup_target : ST_IDLE;
`ifdef APB_WAIT_STATES_EN
            ST_WAIT: begin
                if (access) begin
                    state_next = wait_done ? ST_ACCESS : ST_WAIT;
                end else begin
                    state_next = setup ? setup_target : ST_IDLE;
                end
            end
`endif
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            prdata    <= 32'd0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_wdata <= 32'd0;
            lat_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_next;
            if (setup) begin
                lat_idx   <= idx_lo;
                lat_write <= pwrite;
                lat_wdata <= pwdata;
                lat_err   <= dec_err;
                prdata    <= (dec_err | pwrite) ? 32'd0 : live_rd;
            end
`ifdef APB_WAIT_STATES_EN
            else if (wait_done) begin
                prdata <= (lat_err | lat_write) ? 32'd0 : lat_rd;
            end
`endif
            if (((state == ST_IDLE) && access) || ((state != ST_IDLE) && !access)) begin
                proto_err <= 1'b1;
            end
        end
    end

    assign reg_out[31:0] = ID_VALUE;

    for (genvar i = 1; i < NREGS; i++) begin : g_word
        logic [31:0] word_q;

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset) begin
                word_q <= 32'd0;
            end else if (wr_en && (lat_idx == IDX_W'(i))) begin
                word_q <= lat_wdata;
            end
        end

        assign reg_out[32*i +: 32] = word_q;
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - scoreboard bench for apb_regfile_slave
`timescale 1ns/1ps
module tb_apb_regfile_slave;

    localparam int NREGS = 8;
    localparam logic [2:0] MY_SEL    = 3'b010;
    localparam logic [2:0] OTHER_SEL = 3'b100;

    logic                hclk = 1'b0;
    logic                hreset;
    logic [2:0]          psel;
    logic                penable;
    logic                pwrite;
    logic [31:0]         paddr;
    logic [31:0]         pwdata;
    logic [31:0]         prdata;
    logic                pready;
    logic                pslverr;
    logic [NREGS*32-1:0] reg_out;
    logic                proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int last_waits = 0;
    logic [32:0] exp_q[$];

    apb_regfile_slave #(
        .SEL_IDX    (1),
        .NREGS      (NREGS),
        .ID_VALUE   (32'hA9B0_0001),
        .WAIT_CYCLES(2)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .reg_out  (reg_out),
        .proto_err(proto_err)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return reg_out[32*i +: 32];
    endfunction

    // Scoreboard consumer: every completing access must match the oldest expectation.
    always @(negedge hclk) begin
        if (!hreset && pready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pready", 32'(pready), 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check_eq("prdata", prdata, e[31:0]);
                check_eq("pslverr", 32'(pslverr), 32'(e[32]));
            end
        end
    end

    task automatic apb_xfer(input logic [2:0] s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err);
        int waits;
        logic mine;
        mine    = s[1];
        psel    = s;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        if (mine) exp_q.push_back({exp_err, exp_rd});
        @(posedge hclk); #1;
        penable = 1'b1;
        waits = 0;
        if (mine) begin
            forever begin
                @(negedge hclk);
                if (pready) break;
                waits++;
                if (waits > 20) begin
                    check_eq("pready_timeout", 32'(waits), 32'd0);
                    break;
                end
                @(posedge hclk); #1;
            end
        end else begin
            @(negedge hclk);
            check_eq("desel_pready", 32'(pready), 32'd0);
        end
        last_waits = waits;
        @(posedge hclk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        hreset  = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'd0;
        pwdata  = 32'd0;
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;

        check_eq("rst_pready", 32'(pready), 32'd0);
        check_eq("rst_pslverr", 32'(pslverr), 32'd0);
        check_eq("rst_prdata", prdata, 32'd0);
        check_eq("rst_proto_err", 32'(proto_err), 32'd0);
        check_eq("rst_word1", word(1), 32'd0);
        check_eq("rst_word0", word(0), 32'hA9B0_0001);

        apb_xfer(MY_SEL, 1'b1, 32'h4, 32'hDEADBEEF, 32'd0, 1'b0);
        check_eq("wr_word1", word(1), 32'hDEADBEEF);
`ifndef APB_WAIT_STATES_EN
        check_eq("zero_wait", 32'(last_waits), 32'd0);
`endif
        apb_xfer(MY_SEL, 1'b0, 32'h4, 32'd0, 32'hDEADBEEF, 1'b0);

        apb_xfer(MY_SEL, 1'b0, 32'h0, 32'd0, 32'hA9B0_0001, 1'b0);
        apb_xfer(MY_SEL, 1'b1, 32'h0, 32'h12345678, 32'd0, 1'b1);
        check_eq("id_unchanged", word(0), 32'hA9B0_0001);
        apb_xfer(MY_SEL, 1'b0, 32'h0, 32'd0, 32'hA9B0_0001, 1'b0);

        apb_xfer(MY_SEL, 1'b0, 32'h20, 32'd0, 32'd0, 1'b1);
        apb_xfer(MY_SEL, 1'b1, 32'h6, 32'hCAFEF00D, 32'd0, 1'b1);
        check_eq("misalign_word1", word(1), 32'hDEADBEEF);

        apb_xfer(OTHER_SEL, 1'b1, 32'h8, 32'h55, 32'd0, 1'b0);
        check_eq("desel_word2", word(2), 32'd0);
        check_eq("desel_proto", 32'(proto_err), 32'd0);

        // Setup followed by the select dropping must abort without writing.
        psel = MY_SEL; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h77;
        @(posedge hclk); #1;
        psel = 3'b000;
        @(posedge hclk); #1;
        check_eq("abort_proto", 32'(proto_err), 32'd1);
        check_eq("abort_word3", word(3), 32'd0);
        repeat (3) @(posedge hclk);
        #1 check_eq("proto_sticky", 32'(proto_err), 32'd1);

        apb_xfer(MY_SEL, 1'b1, 32'h8, 32'h1, 32'd0, 1'b0);
        apb_xfer(MY_SEL, 1'b0, 32'h8, 32'd0, 32'h1, 1'b0);
        check_eq("b2b_word2", word(2), 32'h1);

        // Reset asserted in the middle of an access phase.
        psel = MY_SEL; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
        @(posedge hclk); #1;
        penable = 1'b1;
        #1 hreset = 1'b1;
        #1;
        check_eq("midrst_pready", 32'(pready), 32'd0);
        check_eq("midrst_prdata", prdata, 32'd0);
        check_eq("midrst_proto", 32'(proto_err), 32'd0);
        check_eq("midrst_word2", word(2), 32'd0);
        psel = 3'b000; penable = 1'b0;
        @(posedge hclk); #1 hreset = 1'b0;
        apb_xfer(MY_SEL, 1'b0, 32'h8, 32'd0, 32'd0, 1'b0);

`ifdef APB_WAIT_STATES_EN
        apb_xfer(MY_SEL, 1'b1, 32'hC, 32'h0BAD_CAFE, 32'd0, 1'b0);
        check_eq("wait_states", 32'(last_waits), 32'd2);
        check_eq("wait_word3", word(3), 32'h0BAD_CAFE);
`endif

        repeat (2) @(posedge hclk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
